apb_multi_master: RTL
=====================

// Module: apb_multi_master
// PURPOSE
//  Parametrised APB requester bridging a simple valid/ready host request port onto
//  NUM_SLV APB slaves. It decodes the address to one PSELx and runs the APB
//  IDLE/SETUP/ACCESS protocol, muxing PRDATA/PREADY/PSLVERR from the selected slave only.
//  New over the fixed 4-slave master: configurable data/address widths and slave count,
//  an internal address decoder with decode-error response, a wait-state timeout, and a
//  registered response with error code.
// PARAMETERS
//  DW        32   data width (multiple of 8); PSTRB width = DW/8
//  AW        32   address width
//  NUM_SLV   4    number of APB slaves (1..16)
//  SLV_LSB   12   region size per slave = 2^SLV_LSB bytes; slave index = paddr[AW-1:SLV_LSB]
//  TIMEOUT   256  max ACCESS cycles waiting for PREADY; 0 = timeout disabled
// PORTS
//  pclk       in   1           APB clock; all logic on rising edge
//  preset     in   1           async active-low reset
//  req_valid  in   1           host request valid
//  req_ready  out  1           bridge can accept (high only in IDLE)
//  req_addr   in   AW          byte address
//  req_write  in   1           1=write, 0=read
//  req_wdata  in   DW          write data
//  req_strb   in   DW/8        write byte strobes (driven 0 on reads)
//  req_prot   in   3           PPROT value
//  rsp_valid  out  1           one-cycle response pulse
//  rsp_rdata  out  DW          read data (0 for writes/errors)
//  rsp_err    out  2           00 OK, 01 PSLVERR, 10 decode error, 11 timeout
//  psel       out  NUM_SLV     one-hot slave select
//  penable    out  1           APB enable
//  paddr      out  AW          APB address
//  pwrite     out  1           APB direction
//  pprot      out  3           APB protection
//  pwdata     out  DW          APB write data
//  pstrb      out  DW/8        APB strobes
//  prdata     in   NUM_SLV*DW  flattened slave read data, slave i at [i*DW +: DW]
//  pready     in   NUM_SLV     per-slave ready
//  pslverr    in   NUM_SLV     per-slave error
// BEHAVIOUR
//  Reset (async, preset=0): state=IDLE; psel=0, penable=0, paddr/pwdata/pstrb/pprot=0,
//   pwrite=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, timeout counter=0. Reset mid-transfer
//   drops psel/penable immediately; no response is issued for the aborted transfer.
//  States: IDLE, SETUP, ACCESS (2-bit registered state, no latches, all outputs registered).
//  IDLE: req_ready=1. On req_valid: capture addr/write/wdata/strb/prot into the APB output
//   registers; idx = req_addr[AW-1:SLV_LSB].
//   idx < NUM_SLV -> psel[idx]=1, go SETUP. Else -> stay IDLE, next cycle rsp_valid=1,
//   rsp_err=10, and no psel asserted.
//  SETUP: psel held, penable=0, exactly one cycle -> ACCESS (penable=1 next cycle).
//  ACCESS: penable=1; addr/data/ctrl stable. Samples only pready[idx]/pslverr[idx]/prdata[idx];
//   other slaves' inputs are ignored.
//   pready[idx]=1 -> psel=0, penable=0, go IDLE; next cycle rsp_valid=1,
//    rsp_rdata = read ? prdata[idx] : 0, rsp_err = pslverr[idx] ? 01 : 00.
//   pready[idx]=0 -> counter++. If TIMEOUT!=0 and counter reaches TIMEOUT -> abort: psel=0,
//    penable=0, go IDLE; rsp_valid=1, rsp_err=11, rsp_rdata=0.
//  Timeout counter: width $clog2(TIMEOUT+1). Clears on entry to SETUP; saturates, never wraps.
//  Latency: request accepted at edge k -> SETUP in cycle k+1 -> ACCESS in k+2.
//   Zero-wait response rsp_valid in k+3; each wait state adds 1 cycle. Decode error: k+1.
//  Back-to-back: rsp_valid and req_ready are both high in the same IDLE cycle, so a new
//   request may be accepted there; psel goes 1->0->1 (one idle cycle between transfers).
//  req_* inputs are ignored outside IDLE. rsp_rdata/rsp_err hold their value until the
//   next response.
// TESTING
//  1 Write 0x0000_2004, data 0xDEAD_BEEF, strb 0xF, slave2 pready=1 -> psel=0100 in k+1,
//    penable in k+2, rsp_valid k+3, rsp_err=00.
//  2 Read 0x0000_1010, slave1 prdata=0x1234_5678, 3 wait states -> rsp_valid k+6,
//    rsp_rdata=0x1234_5678, paddr stable for all ACCESS cycles.
//  3 Read 0x0000_5000 (idx 5 >= NUM_SLV) -> psel stays 0, rsp_valid k+1, rsp_err=10.
//  4 TIMEOUT=8, slave0 pready held 0 -> abort after 8 ACCESS cycles, rsp_err=11, psel=0.
//  5 Slave3 pslverr=1 with pready; slave0 pready=1 at the same time (ignored) ->
//    rsp_err=01, psel[0] never asserted.
//  6 preset low during ACCESS -> psel/penable=0 in the same cycle, no rsp_valid;
//    a new request after reset completes normally.

Source files
------------

// File: rtl/apb_multi_master.sv
// ============================================================================
// Module   : apb_multi_master
// Brief    : Valid/ready host port to NUM_SLV APB slaves with address decode,
//            wait-state timeout and a registered response carrying an error code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_multi_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    input  logic                  req_write,
    input  logic [DW-1:0]         req_wdata,
    input  logic [DW/8-1:0]       req_strb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic [AW-1:0]         paddr,
    output logic                  pwrite,
    output logic [2:0]            pprot,
    output logic [DW-1:0]         pwdata,
    output logic [DW/8-1:0]       pstrb,
    input  logic [NUM_SLV*DW-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    input  logic [NUM_SLV-1:0]    pslverr
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int XW = AW - SLV_LSB;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_DEC  = 2'b10;
    localparam logic [1:0] c_ERR_TMO  = 2'b11;
    localparam logic [CW-1:0] c_CMAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [NUM_SLV-1:0]  r_psel;
    logic                r_penable;
    logic [AW-1:0]       r_paddr;
    logic                r_pwrite;
    logic [2:0]          r_pprot;
    logic [DW-1:0]       r_pwdata;
    logic [SW-1:0]       r_pstrb;
    logic                r_rsp_valid;
    logic [DW-1:0]       r_rsp_rdata;
    logic [1:0]          r_rsp_err;

    logic [XW-1:0]       w_idx_full;
    logic                w_hit;
    logic [IW-1:0]       w_idx;
    logic                w_sel_rdy;
    logic                w_sel_err;
    logic [DW-1:0]       w_sel_rdata;
    logic                w_tmo;

    assign w_idx_full  = req_addr[AW-1:SLV_LSB];
    assign w_hit       = (w_idx_full < XW'(NUM_SLV));
    assign w_idx       = w_idx_full[IW-1:0];

    // Only the slave captured at request time is ever observed.
    assign w_sel_rdy   = pready[r_idx];
    assign w_sel_err   = pslverr[r_idx];
    assign w_sel_rdata = prdata[int'(r_idx)*DW +: DW];
    assign w_tmo       = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pprot     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= c_ERR_OK;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_paddr  <= req_addr;
                        r_pwrite <= req_write;
                        r_pprot  <= req_prot;
                        r_pwdata <= req_wdata;
                        r_pstrb  <= req_write ? req_strb : '0;
                        if (w_hit) begin
                            r_psel        <= '0;
                            r_psel[w_idx] <= 1'b1;
                            r_idx         <= w_idx;
                            r_cnt         <= '0;
                            r_state       <= S_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= c_ERR_DEC;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A ready on the last allowed cycle still completes normally.
                    if (w_sel_rdy) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : w_sel_rdata;
                        r_rsp_err   <= {1'b0, w_sel_err};
                    end else if (w_tmo) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= c_ERR_TMO;
                    end else begin
                        r_cnt <= (r_cnt == c_CMAX) ? r_cnt : r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pprot     = r_pprot;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;

endmodule

`default_nettype wire
